// File: rtl/mcpu_mem_arbiter_if.sv
// Requester and RAM-side signals of the MCPU memory arbiter, grouped into one bundle.
// The arbiter uses the slave modport; the requesters and the RAM model use master.
interface mcpu_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_rvalid;
    logic [DATA_W-1:0] ldr_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ram_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ram_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mcpu_mem_arbiter.sv
// Registered CPU/loader arbiter for the MCPU single-port RAM; loader has priority, CPU is
// forced through after MAX_WAIT losses. Define MCPU_ARB_LOCK_EN to add the ldr_lock burst input.
module mcpu_mem_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
`ifdef MCPU_ARB_LOCK_EN
    input  logic                ldr_lock,
`endif
    mcpu_mem_arbiter_if.slave   bus
);
    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, CPU_ACC, LDR_ACC} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} owner_t;

    state_t            r_state;
    state_t            w_next;
    owner_t            r_rd_owner;
    logic [3:0]        r_wait_cnt;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;
    logic              w_starved;
    logic              w_lock_hold;

    assign w_starved = bus.cpu_req && (r_wait_cnt == LP_MAX_WAIT);

`ifdef MCPU_ARB_LOCK_EN
    assign w_lock_hold = ldr_lock && bus.ldr_req && (r_state == LDR_ACC);
`else
    assign w_lock_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        if (bus.ldr_req && (w_lock_hold || !w_starved)) w_next = LDR_ACC;
        else if (bus.cpu_req)                            w_next = CPU_ACC;
    end

    // Winner's access is latched alongside the state; an idle cycle leaves ram_* untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else if (w_next == CPU_ACC) begin
            r_ram_we    <= bus.cpu_we;
            r_ram_addr  <= bus.cpu_addr;
            r_ram_wdata <= bus.cpu_wdata;
        end else if (w_next == LDR_ACC) begin
            r_ram_we    <= bus.ldr_we;
            r_ram_addr  <= bus.ldr_addr;
            r_ram_wdata <= bus.ldr_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                   r_wait_cnt <= '0;
        else if (!bus.cpu_req || w_next == CPU_ACC)   r_wait_cnt <= '0;
        else if (r_wait_cnt != LP_MAX_WAIT)           r_wait_cnt <= r_wait_cnt + 4'd1;
    end

    // Owner tag follows the issued read by one cycle, lining up with ram_rdata.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_owner  <= OWN_NONE;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else begin
            if (r_state == CPU_ACC && !r_ram_we)      r_rd_owner <= OWN_CPU;
            else if (r_state == LDR_ACC && !r_ram_we) r_rd_owner <= OWN_LDR;
            else                                      r_rd_owner <= OWN_NONE;
            if (r_rd_owner == OWN_CPU) r_cpu_rdata <= bus.ram_rdata;
            if (r_rd_owner == OWN_LDR) r_ldr_rdata <= bus.ram_rdata;
        end
    end

    always_comb begin
        bus.cpu_gnt    = (r_state == CPU_ACC);
        bus.ldr_gnt    = (r_state == LDR_ACC);
        bus.ram_en     = (r_state != IDLE);
        bus.ram_we     = r_ram_we;
        bus.ram_addr   = r_ram_addr;
        bus.ram_wdata  = r_ram_wdata;
        bus.cpu_rvalid = (r_rd_owner == OWN_CPU);
        bus.ldr_rvalid = (r_rd_owner == OWN_LDR);
        // Fresh RAM data passes straight through in the rvalid cycle, then is held.
        bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_rdata : r_cpu_rdata;
        bus.ldr_rdata  = bus.ldr_rvalid ? bus.ram_rdata : r_ldr_rdata;
    end
endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Directed bench for mcpu_mem_arbiter: per-cycle vector table plus hand sequences for
// reset, starvation, read routing and (with MCPU_ARB_LOCK_EN) locked loader bursts.
module tb_mcpu_mem_arbiter;
    logic clk;
    logic reset;
`ifdef MCPU_ARB_LOCK_EN
    logic ldr_lock;
`endif
    int unsigned total;
    int unsigned bad;

    mcpu_mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    mcpu_mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(4)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef MCPU_ARB_LOCK_EN
        .ldr_lock (ldr_lock),
`endif
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first synchronous RAM model.
    logic [15:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    initial bus.ram_rdata = '0;
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                mem[bus.ram_addr] <= bus.ram_wdata;
                bus.ram_rdata     <= bus.ram_wdata;
            end else begin
                bus.ram_rdata     <= mem[bus.ram_addr];
            end
        end
    end

    typedef struct {
        logic [1:0]  c;      // {cpu_req, cpu_we}
        logic [7:0]  ca;
        logic [15:0] cw;
        logic [1:0]  l;      // {ldr_req, ldr_we}
        logic [7:0]  la;
        logic [15:0] lw;
        logic [5:0]  f;      // {cpu_gnt, ldr_gnt, ram_en, ram_we, cpu_rvalid, ldr_rvalid}
        logic [7:0]  addr;
        logic [15:0] wd;
        logic [15:0] crd;
        logic [15:0] lrd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [7:0] a, input logic [15:0] d);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic set_ldr(input logic req, input logic we, input logic [7:0] a, input logic [15:0] d);
        bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
`ifdef MCPU_ARB_LOCK_EN
        ldr_lock = 1'b0;
`endif
        vecs[0]  = '{2'b00, 8'd0,   16'h0,    2'b11, 8'd100, 16'h5E31, 6'b011100, 8'd100, 16'h5E31, 16'h0,    16'h0};
        vecs[1]  = '{2'b00, 8'd0,   16'h0,    2'b11, 8'd11,  16'h2222, 6'b011100, 8'd11,  16'h2222, 16'h0,    16'h0};
        vecs[2]  = '{2'b00, 8'd0,   16'h0,    2'b10, 8'd11,  16'h0,    6'b011000, 8'd11,  16'h0,    16'h0,    16'h0};
        vecs[3]  = '{2'b10, 8'd100, 16'h0,    2'b00, 8'd0,   16'h0,    6'b101001, 8'd100, 16'h0,    16'h0,    16'h2222};
        vecs[4]  = '{2'b00, 8'd0,   16'h0,    2'b00, 8'd0,   16'h0,    6'b000010, 8'd100, 16'h0,    16'h5E31, 16'h2222};
        vecs[5]  = '{2'b00, 8'd0,   16'h0,    2'b00, 8'd0,   16'h0,    6'b000000, 8'd100, 16'h0,    16'h5E31, 16'h2222};
        vecs[6]  = '{2'b11, 8'd100, 16'h3333, 2'b10, 8'd11,  16'h0,    6'b011000, 8'd11,  16'h0,    16'h5E31, 16'h2222};
        vecs[7]  = '{2'b11, 8'd100, 16'h3333, 2'b10, 8'd100, 16'h0,    6'b011001, 8'd100, 16'h0,    16'h5E31, 16'h2222};
        vecs[8]  = '{2'b11, 8'd100, 16'h3333, 2'b00, 8'd0,   16'h0,    6'b101101, 8'd100, 16'h3333, 16'h5E31, 16'h5E31};
        vecs[9]  = '{2'b10, 8'd100, 16'h0,    2'b00, 8'd0,   16'h0,    6'b101000, 8'd100, 16'h0,    16'h5E31, 16'h5E31};
        vecs[10] = '{2'b00, 8'd0,   16'h0,    2'b00, 8'd0,   16'h0,    6'b000010, 8'd100, 16'h0,    16'h3333, 16'h5E31};

        // Reset held with both requests active: every output stays low.
        reset = 1'b0;
        set_cpu(1'b1, 1'b0, 8'd6, 16'h0);
        set_ldr(1'b1, 1'b1, 8'd5, 16'hABCD);
        tick();
        tick();
        chk("rst cpu_gnt",    32'(bus.cpu_gnt),    0);
        chk("rst ldr_gnt",    32'(bus.ldr_gnt),    0);
        chk("rst ram_en",     32'(bus.ram_en),     0);
        chk("rst ram_we",     32'(bus.ram_we),     0);
        chk("rst ram_addr",   32'(bus.ram_addr),   0);
        chk("rst ram_wdata",  32'(bus.ram_wdata),  0);
        chk("rst cpu_rvalid", 32'(bus.cpu_rvalid), 0);
        chk("rst ldr_rvalid", 32'(bus.ldr_rvalid), 0);
        chk("rst cpu_rdata",  32'(bus.cpu_rdata),  0);
        chk("rst ldr_rdata",  32'(bus.ldr_rdata),  0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release no gnt", 32'({bus.cpu_gnt, bus.ldr_gnt, bus.ram_en}), 0);
        tick();
        chk("first ldr_gnt", 32'(bus.ldr_gnt), 1);
        chk("first cpu_gnt", 32'(bus.cpu_gnt), 0);
        set_cpu(1'b0, 1'b0, 8'd0, 16'h0);
        set_ldr(1'b0, 1'b0, 8'd0, 16'h0);
        tick();

        // Reset lands in the cycle after a CPU read grant: its rvalid must never appear.
        set_cpu(1'b1, 1'b0, 8'd5, 16'h0);
        tick();
        chk("midrst cpu_gnt", 32'(bus.cpu_gnt), 1);
        set_cpu(1'b0, 1'b0, 8'd0, 16'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst ram_en",  32'(bus.ram_en),  0);
        chk("midrst cpu_gnt0", 32'(bus.cpu_gnt), 0);
        tick();
        chk("midrst cpu_rvalid", 32'(bus.cpu_rvalid), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("midrst idle", 32'({bus.cpu_gnt, bus.ldr_gnt, bus.ram_en, bus.cpu_rvalid, bus.ldr_rvalid}), 0);

        for (int v = 0; v < 11; v++) begin
            set_cpu(vecs[v].c[1], vecs[v].c[0], vecs[v].ca, vecs[v].cw);
            set_ldr(vecs[v].l[1], vecs[v].l[0], vecs[v].la, vecs[v].lw);
            tick();
            chk($sformatf("v%0d cpu_gnt", v),    32'(bus.cpu_gnt),    32'(vecs[v].f[5]));
            chk($sformatf("v%0d ldr_gnt", v),    32'(bus.ldr_gnt),    32'(vecs[v].f[4]));
            chk($sformatf("v%0d ram_en", v),     32'(bus.ram_en),     32'(vecs[v].f[3]));
            chk($sformatf("v%0d ram_we", v),     32'(bus.ram_we),     32'(vecs[v].f[2]));
            chk($sformatf("v%0d cpu_rvalid", v), 32'(bus.cpu_rvalid), 32'(vecs[v].f[1]));
            chk($sformatf("v%0d ldr_rvalid", v), 32'(bus.ldr_rvalid), 32'(vecs[v].f[0]));
            chk($sformatf("v%0d ram_addr", v),   32'(bus.ram_addr),   32'(vecs[v].addr));
            chk($sformatf("v%0d ram_wdata", v),  32'(bus.ram_wdata),  32'(vecs[v].wd));
            chk($sformatf("v%0d cpu_rdata", v),  32'(bus.cpu_rdata),  32'(vecs[v].crd));
            chk($sformatf("v%0d ldr_rdata", v),  32'(bus.ldr_rdata),  32'(vecs[v].lrd));
        end

        // Simultaneous reads: loader first, then CPU, each rvalid to its own side only.
        set_ldr(1'b1, 1'b1, 8'd0, 16'hA0A0);
        tick();
        chk("sim wr0 ldr_gnt", 32'(bus.ldr_gnt), 1);
        set_ldr(1'b1, 1'b1, 8'd1, 16'hB1B1);
        tick();
        chk("sim wr1 ldr_gnt", 32'(bus.ldr_gnt), 1);
        set_ldr(1'b1, 1'b0, 8'd0, 16'h0);
        set_cpu(1'b1, 1'b0, 8'd1, 16'h0);
        tick();
        chk("sim ldr_gnt", 32'(bus.ldr_gnt), 1);
        chk("sim cpu_gnt0", 32'(bus.cpu_gnt), 0);
        set_ldr(1'b0, 1'b0, 8'd0, 16'h0);
        tick();
        chk("sim cpu_gnt", 32'(bus.cpu_gnt), 1);
        chk("sim ldr_rvalid", 32'(bus.ldr_rvalid), 1);
        chk("sim cpu_rvalid0", 32'(bus.cpu_rvalid), 0);
        chk("sim ldr_rdata", 32'(bus.ldr_rdata), 32'h0000A0A0);
        set_cpu(1'b0, 1'b0, 8'd0, 16'h0);
        tick();
        chk("sim cpu_rvalid", 32'(bus.cpu_rvalid), 1);
        chk("sim ldr_rvalid0", 32'(bus.ldr_rvalid), 0);
        chk("sim cpu_rdata", 32'(bus.cpu_rdata), 32'h0000B1B1);

        // Both requests held: four loader grants then one forced CPU grant, repeating.
        do_reset();
        set_ldr(1'b1, 1'b0, 8'd2, 16'h0);
        set_cpu(1'b1, 1'b0, 8'd3, 16'h0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("starve%0d cpu_gnt", k), 32'(bus.cpu_gnt), (k % 5 == 0) ? 1 : 0);
            chk($sformatf("starve%0d ldr_gnt", k), 32'(bus.ldr_gnt), (k % 5 == 0) ? 0 : 1);
            chk($sformatf("starve%0d rvalid both", k), 32'(bus.cpu_rvalid & bus.ldr_rvalid), 0);
        end
        set_cpu(1'b0, 1'b0, 8'd0, 16'h0);
        set_ldr(1'b0, 1'b0, 8'd0, 16'h0);

`ifdef MCPU_ARB_LOCK_EN
        // Locked 10-word loader burst holds the bus past MAX_WAIT; CPU wins right after.
        do_reset();
        set_cpu(1'b1, 1'b0, 8'd7, 16'h0);
        ldr_lock = 1'b1;
        for (int w = 0; w < 10; w++) begin
            set_ldr(1'b1, 1'b1, 8'(200 + w), 16'(16'h1000 + w));
            tick();
            chk($sformatf("lock%0d ldr_gnt", w), 32'(bus.ldr_gnt), 1);
            chk($sformatf("lock%0d cpu_gnt", w), 32'(bus.cpu_gnt), 0);
        end
        ldr_lock = 1'b0;
        set_ldr(1'b0, 1'b0, 8'd0, 16'h0);
        tick();
        chk("unlock cpu_gnt", 32'(bus.cpu_gnt), 1);
        set_cpu(1'b0, 1'b0, 8'd0, 16'h0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
